// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit multi-cycle ALU.
// Optional build macro DIV_ZERO_TRAP_EN: flag divide-by-zero on resp_err and finish it in one cycle.
module alu_arbiter #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    input  logic [2:0]  a_sel,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    input  logic [2:0]  b_sel,
    output logic        resp_valid,
    output logic        resp_id,
    input  logic        resp_ready,
    output logic [31:0] resp_r,
    output logic        resp_z,
    output logic        resp_err,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_x, op_y;
    logic [2:0]       op_sel;
    logic             op_id;

    logic             grant_valid, grant_id;
    logic [31:0]      g_y;
    logic [2:0]       g_sel;
    logic [CNT_W-1:0] g_lat;
    logic [31:0]      alu_r;
`ifdef DIV_ZERO_TRAP_EN
    logic             resp_err_q;
`endif

    always_comb begin
        grant_valid = a_valid | b_valid;
        if (a_valid && b_valid) grant_id = rr_ptr;
        else                    grant_id = b_valid;
    end

    assign a_ready = (state == IDLE) && grant_valid && !grant_id;
    assign b_ready = (state == IDLE) && grant_valid &&  grant_id;

    assign g_y   = grant_id ? b_y   : a_y;
    assign g_sel = grant_id ? b_sel : a_sel;

    always_comb begin
        g_lat = CNT_W'(1);
        if (g_sel == 3'd6) g_lat = CNT_W'(MUL_LAT);
        if (g_sel == 3'd7) g_lat = CNT_W'(DIV_LAT);
`ifdef DIV_ZERO_TRAP_EN
        // a zero divisor is known at issue, so skip the divider latency
        if (g_sel == 3'd7 && g_y == 32'd0) g_lat = CNT_W'(1);
`endif
    end

    always_comb begin
        alu_r = 32'd0;
        case (op_sel)
            3'd0: alu_r = op_x + op_y;
            3'd1: alu_r = op_x - op_y;
            3'd2: alu_r = op_x & op_y;
            3'd3: alu_r = op_x | op_y;
            3'd4: alu_r = {31'd0, op_x < op_y};
            3'd5: alu_r = op_x;
            3'd6: alu_r = op_x * op_y;
            3'd7: alu_r = (op_y == 32'd0) ? 32'hFFFF_FFFF : op_x / op_y;
            default: alu_r = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            cnt        <= '0;
            op_x       <= '0;
            op_y       <= '0;
            op_sel     <= '0;
            op_id      <= 1'b0;
            resp_r     <= '0;
`ifdef DIV_ZERO_TRAP_EN
            resp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (grant_valid) begin
                    op_x   <= grant_id ? b_x : a_x;
                    op_y   <= g_y;
                    op_sel <= g_sel;
                    op_id  <= grant_id;
                    rr_ptr <= ~grant_id;
                    cnt    <= g_lat;
                    state  <= EXEC;
                end
                EXEC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        resp_r     <= alu_r;
`ifdef DIV_ZERO_TRAP_EN
                        resp_err_q <= (op_sel == 3'd7) && (op_y == 32'd0);
`endif
                        state      <= RESP;
                    end
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_valid = (state == RESP);
    assign resp_id    = op_id;
    assign resp_z     = (resp_r == 32'd0);
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised transaction-level bench for alu_arbiter against a reference model of the ALU and arbiter.
module tb_alu_arbiter;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [31:0] a_x, a_y, b_x, b_y;
    logic [2:0]  a_sel, b_sel;
    logic        resp_valid, resp_id, resp_ready, resp_z, resp_err, busy;
    logic [31:0] resp_r;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic pri;  // model of which requester wins a tie

    alu_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_sel(a_sel),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_sel(b_sel),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_ready(resp_ready),
        .resp_r(resp_r), .resp_z(resp_z), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_r(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        case (s)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return (x < y) ? 32'd1 : 32'd0;
            3'd5: return x;
            3'd6: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            default: return (y == 0) ? 32'hFFFF_FFFF : x / y;
        endcase
    endfunction

    function automatic bit dz(input logic [2:0] s, input logic [31:0] y);
        return (s == 3'd7) && (y == 0);
    endfunction

    function automatic int ref_lat(input logic [2:0] s, input logic [31:0] y);
        if (s == 3'd6) return MUL_LAT;
`ifdef DIV_ZERO_TRAP_EN
        if (dz(s, y)) return 1;
`endif
        if (s == 3'd7) return DIV_LAT;
        return 1;
    endfunction

    function automatic logic ref_err(input logic [2:0] s, input logic [31:0] y);
`ifdef DIV_ZERO_TRAP_EN
        return dz(s, y);
`else
        return (s == 3'd7) && (y == 0) && 1'b0;
`endif
    endfunction

    // Called at a negedge; presents requests, follows one op to completion, returns at a negedge.
    task automatic issue(input logic av, input logic bv,
                         input logic [2:0] as, input logic [31:0] ax, input logic [31:0] ay,
                         input logic [2:0] bs, input logic [31:0] bx, input logic [31:0] by,
                         input int hold);
        logic        win;
        logic [2:0]  s;
        logic [31:0] x, y, er;
        int n, lat;
        a_valid = av; a_sel = as; a_x = ax; a_y = ay;
        b_valid = bv; b_sel = bs; b_x = bx; b_y = by;
        resp_ready = 1'b0;
        #1;
        n = 0;
        while (!(a_ready || b_ready) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) begin chk("grant_timeout", n, 0); return; end
        win = (av && bv) ? pri : !av;
        chk("grant_b", b_ready, win);
        chk("grant_a", a_ready, !win);
        s = win ? bs : as; x = win ? bx : ax; y = win ? by : ay;
        er = ref_r(s, x, y);
        @(posedge clk);
        pri = ~win;
        @(negedge clk);
        if (win) b_valid = 1'b0; else a_valid = 1'b0;
        #1;
        chk("busy_exec", busy, 1);
        lat = 0;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        if (lat >= 40) begin chk("resp_timeout", lat, ref_lat(s, y)); return; end
        chk("latency", lat, ref_lat(s, y));
        chk("resp_r", resp_r, er);
        chk("resp_z", resp_z, er == 0);
        chk("resp_id", resp_id, win);
        chk("resp_err", resp_err, ref_err(s, y));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_r", resp_r, er);
            chk("hold_id", resp_id, win);
            chk("hold_ready", a_ready | b_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_drop", resp_valid, 0);
        chk("busy_idle", busy, 0);
        resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; resp_ready = 1'b0; pri = 1'b0;
        a_valid = 0; a_x = 0; a_y = 0; a_sel = 0;
        b_valid = 0; b_x = 0; b_y = 0; b_sel = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_r", resp_r, 0);
        chk("rst_z", resp_z, 1);
        chk("rst_err", resp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", a_ready | b_ready, 0);
        @(negedge clk);

        issue(1, 0, 3'd0, 32'd5, 32'd7, 3'd0, 0, 0, 0);
        issue(1, 1, 3'd1, 32'd3, 32'd3, 3'd3, 32'h0F, 32'hF0, 0);
        issue(1, 1, 3'd1, 32'd3, 32'd3, 3'd3, 32'h0F, 32'hF0, 0);
        issue(1, 1, 3'd1, 32'd3, 32'd3, 3'd3, 32'h0F, 32'hF0, 0);
        issue(0, 1, 3'd0, 0, 0, 3'd6, 32'h10000, 32'h10000, 0);
        issue(1, 0, 3'd7, 32'd100, 32'd7, 3'd0, 0, 0, 0);
        issue(1, 0, 3'd4, 32'd2, 32'd9, 3'd0, 0, 0, 5);
        issue(1, 0, 3'd7, 32'd9, 32'd0, 3'd0, 0, 0, 1);

        // reset in the middle of a divide: the op must vanish and A regains priority
        a_valid = 1; a_sel = 3'd7; a_x = 32'd100; a_y = 32'd7; b_valid = 0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        for (int i = 0; i < DIV_LAT + 2; i++) begin
            @(negedge clk);
            chk("no_stale_resp", resp_valid, 0);
        end
        pri = 1'b0;
        issue(1, 1, 3'd2, 32'hF0F0, 32'hFF00, 3'd5, 32'h1234, 32'd0, 0);

        for (int k = 0; k < 40; k++) begin
            logic av, bv;
            logic [31:0] ax, ay, bx, by;
            av = $urandom_range(0, 1);
            bv = av ? 1'($urandom_range(0, 1)) : 1'b1;
            ax = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            bx = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            ay = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 20));
            by = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 20));
            issue(av, bv, 3'($urandom_range(0, 7)), ax, ay, 3'($urandom_range(0, 7)), bx, by,
                  $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit ALU (ops ADD/SUB/AND/OR/SLT/PASS/MUL/DIV, 3-bit SEL) between two requesters, A and B.
- Round-robin arbitration and per-requester valid/ready handshakes.
- Multi-cycle sequencing with configurable MUL/DIV latency.
- Registered result and zero flag returned to the granted requester.
- Sits between the decode/issue logic and the ALU datapath.

Parameters:
- MUL_LAT, 3, cycles spent in EXEC for SEL=6 (>=1).
- DIV_LAT, 8, cycles spent in EXEC for SEL=7 (>=1).
- CNT_W, 4, width of the latency counter; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has an op.
- a_ready  out  1  A's op accepted this cycle.
- a_x, a_y  in  32  A operands.
- a_sel  in  3  A opcode.
- b_valid, b_ready, b_x, b_y, b_sel  same as A, for requester B.
- resp_valid  out  1  result available.
- resp_id  out  1  0 = result belongs to A, 1 = result belongs to B.
- resp_ready  in  1  consumer of resp_id takes the result.
- resp_r  out  32  result.
- resp_z  out  1  1 when resp_r == 0.
- resp_err  out  1  divide-by-zero flag; see Optional Feature.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, rr_ptr=0 (A has priority next).
  - a_ready=b_ready=0, resp_valid=0, resp_id=0.
  - resp_r=0, resp_z=1, resp_err=0, busy=0, counter=0.
  - Reset mid-EXEC or mid-RESP aborts the op with no response.
- a_ready/b_ready are combinational from state: asserted only in IDLE, only for the winner, so at most one is high.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant requester rr_ptr.
  - On any grant, rr_ptr <= ~grant_id.
  - Handshake completes when valid && ready in the same cycle. Operands, sel and id are latched into internal registers that edge.
  - Requester inputs are ignored outside that edge.
- States:
  - IDLE -> EXEC on grant. Counter loads: 1 for SEL 0-5, MUL_LAT for SEL=6, DIV_LAT for SEL=7.
  - EXEC: counter decrements each cycle. When counter==1, the ALU result is registered into resp_r/resp_z/resp_err and the FSM goes to RESP.
  - Latency from accept edge to resp_valid=1: 1 cycle for simple ops, N cycles for MUL/DIV (N = MUL_LAT or DIV_LAT).
  - RESP: resp_valid=1 and the outputs hold stable until resp_ready=1. Then -> IDLE and resp_valid drops next cycle.
  - No new grant in the RESP->IDLE transition cycle; minimum issue interval is 3 cycles.
- Arithmetic (all 32-bit unsigned, wrap-around, no carry out):
  - 0: X+Y.
  - 1: X-Y.
  - 2: X&Y.
  - 3: X|Y.
  - 4: SLT, {31'b0, X<Y} unsigned.
  - 5: pass X.
  - 6: low 32 bits of X*Y.
  - 7: X/Y quotient, truncated.
- resp_z = (resp_r == 0), computed from the registered result.
- A requester holding valid while the other is served waits. Round-robin guarantees service within one intervening op.
- resp_ready while resp_valid=0 is ignored.

Optional Feature:
- Macro DIV_ZERO_TRAP_EN.
- Defined: SEL=7 with Y=0 gives resp_r=32'hFFFFFFFF, resp_err=1, resp_z=0. EXEC is shortened to 1 cycle (early out).
- Undefined: SEL=7 with Y=0 gives resp_r=32'hFFFFFFFF, resp_z=0, normal DIV_LAT latency. resp_err is tied to 0.
- In both builds resp_err=0 for every other op.

Test Plan:
- Reset then A-only: a_sel=0, a_x=5, a_y=7, resp_ready=1. Expect a_ready=1 for one cycle, resp_valid 1 cycle after accept, resp_r=12, resp_id=0, resp_z=0.
- Both valid, back-to-back. A: SUB 3-3. B: OR 0x0F|0xF0.
  - First grant A: resp_r=0, resp_z=1.
  - Next grant B: resp_r=0xFF.
  - Then with both still valid, A is granted again (alternation).
- Latency: B MUL 0x10000*0x10000 gives resp_r=0 (wrap) after MUL_LAT cycles. A DIV 100/7 gives 14 after DIV_LAT cycles. busy=1 throughout.
- Backpressure: SLT 2<9 with resp_ready=0 for 5 cycles. resp_valid, resp_r=1 and resp_id hold stable. a_ready/b_ready stay 0 until resp_ready=1.
- Divide by zero: 9/0.
  - With DIV_ZERO_TRAP_EN: resp_r=0xFFFFFFFF, resp_err=1, latency 1.
  - Without: resp_err=0, latency DIV_LAT.
- Reset mid-EXEC of a DIV: rst=1 for 1 cycle. Next cycle state is IDLE, resp_valid=0, rr_ptr=0. The pending op is never returned.
